p2_ram_ctl: RTL
===============

Name: p2_ram_ctl

Overview:
Parametrised P2-bus memory slave, successor to the fixed 512K x 16 simulation RAM.
- Adds independent byte-lane writes, a configurable base address window and a programmable wait-state generator driving wait_n.
- Adds an explicit access state machine with abort handling.
- Sits on the P2 memory bus behind the CPU-side decode logic and serves as main memory in both simulation and FPGA builds.

Parameters:
- AW, 23, address width in 16-bit words.
- DEPTH, 524288, number of 16-bit words implemented.
- BASE, 0, first word address decoded by this instance.
- WAIT_STATES, 1, extra cycles wait_n is held low before ACCESS (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- addr  input  AW  word address.
- decode  input  1  high when the bus master selects memory space.
- wel_n  input  1  low enables write of datai[7:0].
- weu_n  input  1  low enables write of datai[15:8].
- rw_n  input  1  1 = read, 0 = write.
- go_n  input  1  low = bus cycle in progress.
- wait_n  output  1  low = slave not ready; master must hold the cycle.
- datai  input  16  write data.
- datao  output  16  read data, registered.
- datao_oe  output  1  high while datao must be driven onto the bus (top level builds the tristate).
- oor  output  1  one-cycle pulse: access hit the window but offset >= DEPTH.
- par_err  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a clk edge), regardless of state:
  - state=IDLE, wait_n=1, datao=16'h0000, datao_oe=0, oor=0, par_err=0.
  - Memory contents are not cleared.
- Offset = addr - BASE, computed AW bits wide.
  - In range when addr >= BASE and offset < DEPTH.
  - Window hit when addr >= BASE.
- IDLE:
  - Condition: go_n=0 and decode=1 sampled.
  - Actions: latch addr, rw_n, wel_n, weu_n, datai; load counter = WAIT_STATES; wait_n<=0.
  - Next state: WAIT if WAIT_STATES>0, else ACCESS.
- WAIT:
  - Decrement the counter each cycle.
  - Go to ACCESS when the counter reaches 1.
  - wait_n stays 0.
- ACCESS (exactly one cycle):
  - Write, in range: write each enabled byte lane; disabled lanes are unchanged; both lanes disabled leaves memory unchanged and the cycle still completes.
  - Read, in range: datao <= mem[offset].
  - Read, out of range: datao <= 16'hFFFF.
  - Out-of-range write: dropped.
  - Out of range but window hit: oor=1 for this cycle only.
  - wait_n <= 1. datao_oe <= 1 for reads only. Next state DONE.
- DONE:
  - Hold datao, datao_oe and wait_n=1 until go_n=1 is sampled.
  - On that edge: datao_oe<=0, go to IDLE. datao retains its value.
  - A new cycle is accepted only from IDLE, so go_n must go high for at least one cycle between accesses.
- Latency from the go_n-low sample edge (cycle 0):
  - wait_n low in cycles 1..WAIT_STATES+1.
  - datao valid and wait_n high from cycle WAIT_STATES+2.
- Abort: go_n=1 sampled in WAIT or ACCESS-entry → return to IDLE, wait_n<=1, no memory write, datao unchanged, oor=0.
- decode=0 with go_n=0: ignored. wait_n stays 1 and datao_oe stays 0 (other slaves own the cycle).
- Inputs changing during WAIT/ACCESS have no effect; latched values are used.

Optional Feature:
Macro P2_RAM_PARITY_EN.
- Defined:
  - One parity bit per byte lane is stored alongside the data and written with its lane.
  - On an in-range read in ACCESS, stored parity is compared with recomputed even parity of the read bytes.
  - Any mismatch sets par_err=1, which holds until reset.
  - Parity storage is initialised consistent with memory preload.
- Undefined: no parity storage; par_err is tied to 0.

Test Plan:
- WAIT_STATES=1, BASE=0: write 16'hA55A to addr 0x10 with wel_n=weu_n=0, then read 0x10 → datao=16'hA55A, wait_n low exactly 2 cycles, datao_oe=1 from cycle 3 until go_n rises.
- Byte lanes: write 16'h1234 to 0x20, then write 16'hFFFF with wel_n=0, weu_n=1 → read returns 16'h12FF. Then write 16'h00AA with weu_n=0 only → 16'h00FF.
- Range: BASE=16'h0100, DEPTH=256. Read addr 0x0200 → datao=16'hFFFF, oor pulses once. Write to 0x0200 leaves all memory unchanged. Read addr 0x00FF → ignored, wait_n stays 1.
- Abort: WAIT_STATES=3, start a write of 16'hBEEF to 0x30, raise go_n in cycle 2 → FSM returns to IDLE, wait_n=1 next cycle, a later read of 0x30 returns the prior value.
- Reset mid-access: assert reset_n=0 during WAIT → next edge wait_n=1, datao=0, datao_oe=0, IDLE; a fresh read afterwards completes normally. Sweep WAIT_STATES 0 and 15, checking datao valid at cycles 2 and 17.
- With P2_RAM_PARITY_EN: force a stored parity bit inverted at 0x40, then read → par_err=1 and stays 1 across further clean reads until reset.

Source files
------------

// File: rtl/p2_ram_ctl.sv
// -----------------------------------------------------------------------------
// p2_ram_ctl -- parametrised P2-bus memory slave.
//
// Word-addressed 16-bit RAM with independent byte-lane writes, a base-address
// window, a programmable wait-state generator on wait_n and an access FSM
// (IDLE -> WAIT -> ACCESS -> DONE) that drops the cycle when the master
// releases go_n early.
//
// Optional feature: define P2_RAM_PARITY_EN to store one even-parity bit per
// byte lane and raise a sticky par_err on a read whose stored parity does not
// match its data. Without the macro par_err is tied low.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   addr      word address (AW bits)
//   decode    master selects memory space
//   wel_n     low: write datai[7:0]
//   weu_n     low: write datai[15:8]
//   rw_n      1 = read, 0 = write
//   go_n      low: bus cycle in progress
//   wait_n    low: slave not ready
//   datai     write data
//   datao     registered read data
//   datao_oe  datao must be driven onto the bus
//   oor       one-cycle pulse: window hit but offset >= DEPTH
//   par_err   sticky parity error
// -----------------------------------------------------------------------------
module p2_ram_ctl #(
  parameter int AW          = 23,
  parameter int DEPTH       = 524288,
  parameter int BASE        = 0,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  input  logic          decode,
  input  logic          wel_n,
  input  logic          weu_n,
  input  logic          rw_n,
  input  logic          go_n,
  output logic          wait_n,
  input  logic [15:0]   datai,
  output logic [15:0]   datao,
  output logic          datao_oe,
  output logic          oor,
  output logic          par_err
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] BASE_W  = AW'(BASE);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Request attributes captured at acceptance; later bus changes are ignored.
  logic [AW-1:0] addr_q;
  logic          rw_q, wel_q, weu_q;
  logic [15:0]   data_q;

  logic          accept, do_access, abort, release_bus;
  logic [AW-1:0] off_q;
  logic          in_range;
  logic [IW-1:0] idx;
  logic          wr_en;

  logic [15:0] mem [DEPTH];

  // Only addresses at or above BASE are claimed; the rest belong to other slaves.
  wire win_hit = (addr >= BASE_W);

  // Acceptance already guarantees addr_q >= BASE, so the offset cannot wrap.
  assign off_q    = addr_q - BASE_W;
  assign in_range = ({1'b0, off_q} < DEPTH_W);
  assign idx      = off_q[IW-1:0];
  assign wr_en    = do_access && !rw_q && in_range;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    do_access   = 1'b0;
    abort       = 1'b0;
    release_bus = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!go_n && decode && win_hit) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (go_n) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (go_n) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          do_access = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (go_n) begin
          release_bus = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wait_n   <= 1'b1;
      datao    <= 16'h0000;
      datao_oe <= 1'b0;
      oor      <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b1;
      wel_q    <= 1'b1;
      weu_q    <= 1'b1;
      data_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oor     <= 1'b0;
      if (accept) begin
        addr_q <= addr;
        rw_q   <= rw_n;
        wel_q  <= wel_n;
        weu_q  <= weu_n;
        data_q <= datai;
        wait_n <= 1'b0;
      end
      if (abort) wait_n <= 1'b1;
      if (do_access) begin
        wait_n   <= 1'b1;
        datao_oe <= rw_q;
        oor      <= !in_range;
        if (rw_q) datao <= in_range ? mem[idx] : 16'hFFFF;
      end
      if (release_bus) datao_oe <= 1'b0;
    end
  end

  // NOTE: the memory array has no reset; contents survive reset_n and the
  // array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!wel_q) mem[idx][7:0]  <= data_q[7:0];
      if (!weu_q) mem[idx][15:8] <= data_q[15:8];
    end
  end

`ifdef P2_RAM_PARITY_EN
  // Bit 0 guards the lower byte, bit 1 the upper byte; each bit makes its
  // byte plus parity carry an even number of ones.
  logic [1:0]  par_mem [DEPTH];
  logic [15:0] rd_word;
  logic [1:0]  rd_par;

  assign rd_word = mem[idx];
  assign rd_par  = par_mem[idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!wel_q) par_mem[idx][0] <= ^data_q[7:0];
      if (!weu_q) par_mem[idx][1] <= ^data_q[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_err <= 1'b0;
    end else if (do_access && rw_q && in_range &&
                 (rd_par != {^rd_word[15:8], ^rd_word[7:0]})) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
